// File: rtl/button_event_reader_pkg.sv
// -----------------------------------------------------------------------------
// button_event_reader_pkg
// Shared definitions for the button event reader: per-channel FSM state
// encoding and the width of the debounce / hold counters.
// -----------------------------------------------------------------------------
package button_event_reader_pkg;

  // Width of the debounce (dcnt) and hold (hcnt) counters.
  localparam int CNT_W = 32;

  // Per-channel debounce / hold state.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,  // debounced level 0, input quiet
    ARM_PRESS   = 2'd1,  // level 0, counting stable-high samples
    HELD        = 2'd2,  // level 1, running the hold/repeat timer
    ARM_RELEASE = 2'd3   // level 1, counting stable-low samples
  } btn_state_e;

endpackage : button_event_reader_pkg

// File: rtl/button_event_reader_btn_debounce_channel.sv
// -----------------------------------------------------------------------------
// btn_debounce_channel
// One button channel: 2-flop synchroniser, debounce FSM and hold/repeat timer.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_i      raw button pin (asynchronous, active-high)
//   level_o    debounced button state
//   press_o    one-cycle pulse when a debounced press is accepted
//   release_o  one-cycle pulse when a debounced release is accepted
//   repeat_o   one-cycle pulse while held: first HOLD_CYCLES after the press
//              pulse, then every REPEAT_CYCLES
// -----------------------------------------------------------------------------
module btn_debounce_channel
  import button_event_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  btn_state_e       state_q;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic             first_q;   // 1 once the first repeat of this hold has fired
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             repeat_q;
  logic             hold_hit;

  // Two-flop synchroniser for the asynchronous pin.
  // NOTE: every clocked register uses <= so all flops sample the pre-edge
  // values; blocking assignments here would collapse the chain into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn_i};
  end

  assign s = sync_q[1];

  // The hold timer compares against the first-repeat distance until the first
  // repeat has fired, then against the repeat period.
  assign hold_hit = first_q ? (hcnt_q == REP_LAST) : (hcnt_q == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      first_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      // Event outputs are single-cycle: cleared every edge unless set below.
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (s) begin
            state_q <= ARM_PRESS;
            dcnt_q  <= CNT_W'(1);
          end
        end

        ARM_PRESS: begin
          if (!s) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
          end else if (dcnt_q == DEB_LAST) begin
            state_q <= HELD;
            level_q <= 1'b1;
            press_q <= 1'b1;
            hcnt_q  <= '0;
            first_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end

        HELD: begin
          if (!s) begin
            // hcnt is frozen while a possible release is being qualified.
            state_q <= ARM_RELEASE;
            dcnt_q  <= CNT_W'(1);
          end else if (hold_hit) begin
            repeat_q <= 1'b1;
            hcnt_q   <= '0;
            first_q  <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + CNT_W'(1);
          end
        end

        ARM_RELEASE: begin
          if (s) begin
            // Release bounce: back to HELD, and the hold timer resumes on this
            // same edge, so the repeat schedule slips only by the low samples.
            state_q <= HELD;
            if (hold_hit) begin
              repeat_q <= 1'b1;
              hcnt_q   <= '0;
              first_q  <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + CNT_W'(1);
            end
          end else if (dcnt_q == DEB_LAST) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            first_q   <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule : btn_debounce_channel

// File: rtl/button_event_reader.sv
// -----------------------------------------------------------------------------
// button_event_reader
// Reads N_BTN raw push-buttons, synchronises and debounces each one, and emits
// a clean level plus single-cycle press / release / auto-repeat pulses per
// button. All outputs are in the clk domain; channels are fully independent.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_i      [N_BTN] raw button pins (asynchronous, active-high)
//   level_o    [N_BTN] debounced button state
//   press_o    [N_BTN] one-cycle pulse per accepted press
//   release_o  [N_BTN] one-cycle pulse per accepted release
//   repeat_o   [N_BTN] one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_event_reader
  import button_event_reader_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] repeat_o
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule : button_event_reader

// File: tb/tb_button_event_reader.sv
// -----------------------------------------------------------------------------
// tb_button_event_reader
// Self-checking bench for button_event_reader with short timing parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_button_event_reader;

  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic [NB-1:0] level_w, press_w, release_w, repeat_w;

  button_event_reader #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn),
    .level_o  (level_w),
    .press_o  (press_w),
    .release_o(release_w),
    .repeat_o (repeat_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------- model ---
  // Behavioural view: the FSM sees the pin two edges late; a level change is
  // accepted once the delayed pin has differed from the level for DEB edges in
  // a row; while pressed, every edge with the pin high is one tick of hold
  // time, and repeats fire at tick HOLD, HOLD+REP, HOLD+2*REP, ...
  logic [NB-1:0] m_d1, m_d2, m_lvl, m_pr, m_rl, m_rp;
  int            m_run [NB];
  int            m_tick[NB];

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0;
    m_pr = '0; m_rl = '0; m_rp = '0;
    for (int i = 0; i < NB; i++) begin
      m_run[i]  = 0;
      m_tick[i] = 0;
    end
  endtask

  task automatic model_step(input logic [NB-1:0] b);
    logic [NB-1:0] s;
    s    = m_d2;
    m_d2 = m_d1;
    m_d1 = b;
    m_pr = '0; m_rl = '0; m_rp = '0;
    for (int i = 0; i < NB; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_run[i]  = 0;
          m_lvl[i]  = s[i];
          m_tick[i] = 0;
          if (s[i]) m_pr[i] = 1'b1;
          else      m_rl[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
        if (m_lvl[i]) begin
          m_tick[i]++;
          if (m_tick[i] == HOLD ||
              (m_tick[i] > HOLD && (m_tick[i] - HOLD) % REP == 0))
            m_rp[i] = 1'b1;
        end
      end
    end
  endtask

  // ------------------------------------------------------------- checking ---
  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got '%s', want '%s'", name, act, exp);
    end
  endtask

  // Pulse logs (edge numbers, relative to the last clear_log) and counts.
  string press_log[NB], rel_log[NB], rep_log[NB];
  int    cnt_pr[NB], cnt_rl[NB], cnt_rp[NB];
  int    edge_n;

  function automatic string log_add(input string s, input int e);
    return (s == "") ? $sformatf("%0d", e) : {s, " ", $sformatf("%0d", e)};
  endfunction

  task automatic clear_log();
    edge_n = 0;
    for (int i = 0; i < NB; i++) begin
      press_log[i] = ""; rel_log[i] = ""; rep_log[i] = "";
      cnt_pr[i] = 0; cnt_rl[i] = 0; cnt_rp[i] = 0;
    end
  endtask

  // One clock: drive btn, let the edge happen, advance the model, then sample
  // on the falling edge and compare everything against the model.
  task automatic cycle(input logic [NB-1:0] b);
    btn = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
    check("model", {level_w, press_w, release_w, repeat_w},
                   {m_lvl, m_pr, m_rl, m_rp});
    for (int i = 0; i < NB; i++) begin
      if (press_w[i])   begin press_log[i] = log_add(press_log[i], edge_n); cnt_pr[i]++; end
      if (release_w[i]) begin rel_log[i]   = log_add(rel_log[i], edge_n);   cnt_rl[i]++; end
      if (repeat_w[i])  begin rep_log[i]   = log_add(rep_log[i], edge_n);   cnt_rp[i]++; end
    end
    edge_n++;
  endtask

  task automatic run(input logic [NB-1:0] b, input int n);
    for (int k = 0; k < n; k++) cycle(b);
  endtask

  // Reset held across clock edges; returns on a falling edge with rst low.
  task automatic hard_reset();
    btn = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", {level_w, press_w, release_w, repeat_w}, 16'h0000);
    model_reset();
    rst = 1'b0;
    clear_log();
  endtask

  // Short reset pulse between edges; outputs must clear without any clock.
  task automatic async_reset_pulse();
    #1 rst = 1'b1;
    #1 check("async_reset", {level_w, press_w, release_w, repeat_w}, 16'h0000);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- table ---
  // Each record: pin value held for n edges, then the expected level at the
  // end and pulse counts during the record (nibble i = count for button i).
  typedef struct {
    logic [NB-1:0] b;
    int            n;
    logic [NB-1:0] lvl;
    logic [15:0]   pr;
    logic [15:0]   rl;
    logic [15:0]   rp;
  } seg_t;

  seg_t        tbl[10];
  logic [15:0] a_pr, a_rl, a_rp;
  int          rem[NB];
  logic [NB-1:0] rb;

  initial begin
    tbl[0] = '{4'b0001,  6, 4'b0001, 16'h0001, 16'h0000, 16'h0000}; // clean press
    tbl[1] = '{4'b0001, 10, 4'b0001, 16'h0000, 16'h0000, 16'h0001}; // first repeat
    tbl[2] = '{4'b0001,  6, 4'b0001, 16'h0000, 16'h0000, 16'h0002}; // periodic
    tbl[3] = '{4'b0000,  6, 4'b0000, 16'h0000, 16'h0001, 16'h0000}; // release
    tbl[4] = '{4'b0010,  3, 4'b0000, 16'h0000, 16'h0000, 16'h0000}; // bounce
    tbl[5] = '{4'b0000,  2, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[6] = '{4'b0010,  2, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[7] = '{4'b0000,  6, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[8] = '{4'b1111,  6, 4'b1111, 16'h1111, 16'h0000, 16'h0000}; // all at once
    tbl[9] = '{4'b0000,  6, 4'b0000, 16'h0000, 16'h1111, 16'h0000};

    hard_reset();
    for (int t = 0; t < 10; t++) begin
      clear_log();
      run(tbl[t].b, tbl[t].n);
      for (int i = 0; i < NB; i++) begin
        a_pr[i*4 +: 4] = 4'(cnt_pr[i]);
        a_rl[i*4 +: 4] = 4'(cnt_rl[i]);
        a_rp[i*4 +: 4] = 4'(cnt_rp[i]);
      end
      check($sformatf("tbl%0d_level", t), 16'(level_w), 16'(tbl[t].lvl));
      check($sformatf("tbl%0d_press", t), a_pr, tbl[t].pr);
      check($sformatf("tbl%0d_release", t), a_rl, tbl[t].rl);
      check($sformatf("tbl%0d_repeat", t), a_rp, tbl[t].rp);
    end

    // Hold / repeat / release timing on button 2.
    hard_reset();
    run(4'b0100, 36);
    run(4'b0000, 10);
    check_s("hold_press2", press_log[2], "5");
    check_s("hold_repeat2", rep_log[2], "15 18 21 24 27 30 33 36");
    check_s("hold_release2", rel_log[2], "41");

    // Release bounce on button 3: two low samples shift repeats by two.
    hard_reset();
    run(4'b1000, 8);
    run(4'b0000, 2);
    run(4'b1000, 20);
    check_s("rbounce_press3", press_log[3], "5");
    check_s("rbounce_repeat3", rep_log[3], "17 20 23 26 29");
    check_s("rbounce_release3", rel_log[3], "");
    check("rbounce_level", 16'(level_w), 16'h0008);

    // Asynchronous reset mid-hold, button still down afterwards.
    hard_reset();
    run(4'b0001, 8);
    check("prereset_level", 16'(level_w), 16'h0001);
    async_reset_pulse();
    clear_log();
    run(4'b0001, 8);
    check_s("postreset_press0", press_log[0], "5");
    check("postreset_level", 16'(level_w), 16'h0001);

    // Simultaneous press on all buttons lands on the same edge.
    hard_reset();
    run(4'b1111, 7);
    for (int i = 0; i < NB; i++)
      check_s($sformatf("simul_press%0d", i), press_log[i], "5");

    // Randomised runs of mixed short (bounce) and long (hold) levels, with the
    // occasional asynchronous reset; every cycle compared against the model.
    hard_reset();
    rb = '0;
    for (int i = 0; i < NB; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (rem[i] == 0) begin
          rb[i]  = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 8));
        end
        rem[i]--;
      end
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
      cycle(rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_button_event_reader
